// File: rtl/multi_unit_clock_ctl.sv
// ----------------------------------------------------------------------------
// multi_unit_clock_ctl
//   NUM_CH independent unit-clock generators, each dividing CRCU_CLK by a
//   software-selected even ratio (12/10/6/4/2) with glitch-free ratio changes
//   and clean start/stop.
//
// Ports
//   CRCU_CLK            source clock, all state on the rising edge
//   CRCU_RST_N          asynchronous active-low reset
//   unit_clock_ctl_reg  per-channel 32-bit control word:
//                       [2:0] sel, [3] clk_en, [4] clk_gate, [31:5] unused
//   unit_clk            registered divided clock per channel
//   clk_active          1 while the channel FSM is not in STOP
//   sw_pending          1 while a ratio change is latched but not yet applied
// ----------------------------------------------------------------------------
module multi_unit_clock_ctl #(
  parameter int unsigned NUM_CH  = 4,
  parameter logic [2:0]  RST_SEL = 3'b000
) (
  input  logic                   CRCU_CLK,
  input  logic                   CRCU_RST_N,
  input  logic [NUM_CH*32-1:0]   unit_clock_ctl_reg,
  output logic [NUM_CH-1:0]      unit_clk,
  output logic [NUM_CH-1:0]      clk_active,
  output logic [NUM_CH-1:0]      sw_pending
);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_e;

  // Decode a select code to {valid, half-period}; unused codes are invalid.
  function automatic logic [3:0] sel_to_half(input logic [2:0] sel);
    case (sel)
      3'b000:  sel_to_half = {1'b1, 3'd6};
      3'b001:  sel_to_half = {1'b1, 3'd5};
      3'b010:  sel_to_half = {1'b1, 3'd3};
      3'b011:  sel_to_half = {1'b1, 3'd2};
      3'b100:  sel_to_half = {1'b1, 3'd1};
      default: sel_to_half = {1'b0, 3'd0};
    endcase
  endfunction

  localparam logic [3:0] RST_DEC  = sel_to_half(RST_SEL);
  // An invalid reset code falls back to the slowest ratio.
  localparam logic [2:0] RST_HALF = RST_DEC[3] ? RST_DEC[2:0] : 3'd6;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [2:0] cur_half_q, cur_half_d;
    logic [2:0] pend_half_q, pend_half_d;
    logic       pend_q, pend_d;
    logic       uclk_q, uclk_d;
    logic       act_q, act_d;
    logic       run_s;
    logic       sel_valid_s;
    logic [2:0] sel_half_s;
    logic       rise_s;
    logic       unused_ctl_s;

    assign run_s = unit_clock_ctl_reg[32*g+3] & ~unit_clock_ctl_reg[32*g+4];
    assign {sel_valid_s, sel_half_s} = sel_to_half(unit_clock_ctl_reg[32*g +: 3]);
    assign unused_ctl_s = ^unit_clock_ctl_reg[32*g+5 +: 27];

    // Phase FSM: counts half-period cycles in LOW and HIGH.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      uclk_d  = uclk_q;
      rise_s  = 1'b0;
      case (state_q)
        ST_STOP: begin
          uclk_d = 1'b0;
          cnt_d  = 3'd0;
          if (run_s) begin
            state_d = ST_LOW;
          end else begin
            state_d = ST_STOP;
          end
        end
        ST_LOW: begin
          uclk_d = 1'b0;
          if (!run_s) begin
            // Output is already low, so stopping here cannot leave a runt.
            state_d = ST_STOP;
            cnt_d   = 3'd0;
          end else if (cnt_q == cur_half_q - 3'd1) begin
            state_d = ST_HIGH;
            uclk_d  = 1'b1;
            cnt_d   = 3'd0;
            rise_s  = 1'b1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        ST_HIGH: begin
          uclk_d = 1'b1;
          if (cnt_q == cur_half_q - 3'd1) begin
            uclk_d  = 1'b0;
            cnt_d   = 3'd0;
            state_d = run_s ? ST_LOW : ST_STOP;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        default: begin
          state_d = ST_STOP;
          cnt_d   = 3'd0;
          uclk_d  = 1'b0;
        end
      endcase
      act_d = (state_d != ST_STOP);
    end

    // Ratio bookkeeping. A new ratio only takes effect at a rise (a fresh
    // high phase) or while stopped, so no phase is ever cut short. While
    // stopped a valid select is taken directly, so a start never runs one
    // period at a stale ratio.
    always_comb begin
      cur_half_d  = cur_half_q;
      pend_half_d = pend_half_q;
      pend_d      = pend_q;
      if ((state_q == ST_STOP) && sel_valid_s) begin
        cur_half_d = sel_half_s;
        pend_d     = 1'b0;
      end else if (((state_q == ST_STOP) || rise_s) && pend_q) begin
        cur_half_d = pend_half_q;
        pend_d     = 1'b0;
      end else begin
        cur_half_d = cur_half_q;
      end
      // Compared against the post-apply ratio so an applied change does not
      // immediately re-arm itself.
      if (sel_valid_s) begin
        if (sel_half_s != cur_half_d) begin
          pend_d      = 1'b1;
          pend_half_d = sel_half_s;
        end else begin
          pend_d = 1'b0;
        end
      end else begin
        pend_half_d = pend_half_q;
      end
    end

    // Channel state registers.
    always_ff @(posedge CRCU_CLK or negedge CRCU_RST_N) begin
      if (!CRCU_RST_N) begin
        state_q     <= ST_STOP;
        cnt_q       <= 3'd0;
        uclk_q      <= 1'b0;
        act_q       <= 1'b0;
        pend_q      <= 1'b0;
        pend_half_q <= RST_HALF;
        cur_half_q  <= RST_HALF;
      end else begin
        state_q     <= state_d;
        cnt_q       <= cnt_d;
        uclk_q      <= uclk_d;
        act_q       <= act_d;
        pend_q      <= pend_d;
        pend_half_q <= pend_half_d;
        cur_half_q  <= cur_half_d;
      end
    end

    assign unit_clk[g]   = uclk_q;
    assign clk_active[g] = act_q;
    assign sw_pending[g] = pend_q;
  end

endmodule

// File: tb/tb_multi_unit_clock_ctl.sv
// ----------------------------------------------------------------------------
// Testbench for multi_unit_clock_ctl. Stimulus pushes expected unit_clk
// phases (level, length in cycles; length 0 = any) into per-channel queues;
// a monitor measures each completed phase and compares it with the queue head.
// Status outputs are checked directly at chosen points.
// ----------------------------------------------------------------------------
module tb_multi_unit_clock_ctl;

  localparam int NCH = 4;

  logic               clk;
  logic               rst_n;
  logic [NCH*32-1:0]  ctrl;
  logic [NCH-1:0]     unit_clk;
  logic [NCH-1:0]     clk_active;
  logic [NCH-1:0]     sw_pending;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic lvl;
    int   len;
  } ph_t;

  ph_t exp_q [NCH][$];

  multi_unit_clock_ctl #(.NUM_CH(NCH), .RST_SEL(3'b000)) dut (
    .CRCU_CLK           (clk),
    .CRCU_RST_N         (rst_n),
    .unit_clock_ctl_reg (ctrl),
    .unit_clk           (unit_clk),
    .clk_active         (clk_active),
    .sw_pending         (sw_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  task automatic set_ch(input int ch, input logic [2:0] sel, input logic en, input logic gate);
    ctrl[ch*32 +: 32] = {27'd0, gate, en, sel};
  endtask

  task automatic push(input int ch, input logic lvl, input int len);
    ph_t p;
    p.lvl = lvl;
    p.len = len;
    exp_q[ch].push_back(p);
  endtask

  // Waits for a 0->1 edge of unit_clk[ch]; n = negedges waited, last_pend =
  // sw_pending[ch] in the sample just before the rise.
  task automatic wait_rise(input int ch, input int max_cyc, input string tag,
                           output int n, output logic last_pend);
    logic p;
    logic lp;
    p = unit_clk[ch];
    n = 0;
    last_pend = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      lp = sw_pending[ch];
      @(negedge clk);
      n++;
      if (p == 1'b0 && unit_clk[ch] == 1'b1) begin
        last_pend = lp;
        return;
      end
      p = unit_clk[ch];
    end
    checks++;
    errors++;
    $display("FAIL %s: no rise on ch%0d within %0d cycles", tag, ch, max_cyc);
    n = -1;
  endtask

  task automatic drain(input int max_cyc, input string tag);
    int left;
    for (int i = 0; i < max_cyc; i++) begin
      left = 0;
      for (int c = 0; c < NCH; c++) left += exp_q[c].size();
      if (left == 0) return;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL %s: expected phases still outstanding after %0d cycles", tag, max_cyc);
    for (int c = 0; c < NCH; c++) exp_q[c].delete();
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    ctrl = '0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Monitor: measures each completed unit_clk phase and checks it.
  initial begin
    logic prev [NCH];
    int   run  [NCH];
    ph_t  e;
    for (int c = 0; c < NCH; c++) begin
      prev[c] = 1'b0;
      run[c]  = 0;
    end
    forever begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
        if (!rst_n) begin
          prev[c] = 1'b0;
          run[c]  = 0;
        end else if (unit_clk[c] === prev[c]) begin
          run[c]++;
        end else begin
          if (exp_q[c].size() > 0) begin
            e = exp_q[c].pop_front();
            checks++;
            if (e.lvl !== prev[c] || (e.len != 0 && e.len != run[c])) begin
              errors++;
              $display("FAIL phase ch%0d: got level %0d for %0d cycles, expected level %0d for %0d cycles",
                       c, prev[c], run[c], e.lvl, e.len);
            end
          end
          prev[c] = unit_clk[c];
          run[c]  = 1;
        end
      end
    end
  end

  initial begin
    int   n;
    logic lp;

    rst_n = 1'b0;
    ctrl  = '0;
    #1;
    chk("reset unit_clk", unit_clk, 4'h0);
    chk("reset clk_active", clk_active, 4'h0);
    chk("reset sw_pending", sw_pending, 4'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Ch0 ratio 4 from reset: 2 high / 2 low, active from first LOW.
    @(negedge clk);
    set_ch(0, 3'b011, 1'b1, 1'b0);
    push(0, 1'b0, 0);
    for (int k = 0; k < 3; k++) begin
      push(0, 1'b1, 2);
      if (k < 2) push(0, 1'b0, 2);
    end
    chk("A act0 before edge", clk_active[0], 1'b0);
    @(negedge clk);
    chk("A act0 first LOW", clk_active[0], 1'b1);
    chk("A unit_clk0 first LOW", unit_clk[0], 1'b0);
    chk("A pend0", sw_pending[0], 1'b0);
    drain(100, "A drain");

    // Ch1 ratio 12, switch to ratio 2 in the middle of the second high phase.
    reset_pulse();
    set_ch(1, 3'b000, 1'b1, 1'b0);
    push(1, 1'b0, 0);
    push(1, 1'b1, 6); push(1, 1'b0, 6);
    push(1, 1'b1, 6); push(1, 1'b0, 6);
    push(1, 1'b1, 1); push(1, 1'b0, 1);
    push(1, 1'b1, 1); push(1, 1'b0, 1);
    @(negedge clk);
    chk("B pend1 same ratio", sw_pending[1], 1'b0);
    wait_rise(1, 40, "B rise1", n, lp);
    wait_rise(1, 40, "B rise2", n, lp);
    @(negedge clk);
    set_ch(1, 3'b100, 1'b1, 1'b0);
    @(negedge clk);
    chk("B pend1 set", sw_pending[1], 1'b1);
    chk("B unit_clk1 still high", unit_clk[1], 1'b1);
    wait_rise(1, 40, "B rise3", n, lp);
    chk("B pend1 before rise", lp, 1'b1);
    chk("B pend1 cleared at rise", sw_pending[1], 1'b0);
    drain(100, "B drain");

    // Ch2 ratio 6, gated during the second high phase, then ungated.
    reset_pulse();
    set_ch(2, 3'b010, 1'b1, 1'b0);
    push(2, 1'b0, 0);
    push(2, 1'b1, 3); push(2, 1'b0, 3); push(2, 1'b1, 3);
    wait_rise(2, 40, "C rise1", n, lp);
    wait_rise(2, 40, "C rise2", n, lp);
    @(negedge clk);
    set_ch(2, 3'b010, 1'b1, 1'b1);
    for (int i = 0; i < 10 && unit_clk[2] == 1'b1; i++) @(negedge clk);
    chk("C unit_clk2 after high", unit_clk[2], 1'b0);
    chk("C act2 stopped", clk_active[2], 1'b0);
    repeat (4) @(negedge clk);
    chk("C unit_clk2 held low", unit_clk[2], 1'b0);
    chk("C act2 held", clk_active[2], 1'b0);
    drain(20, "C drain1");
    push(2, 1'b0, 0);
    push(2, 1'b1, 3);
    set_ch(2, 3'b010, 1'b1, 1'b0);
    @(negedge clk);
    chk("C act2 restart", clk_active[2], 1'b1);
    wait_rise(2, 20, "C restart rise", n, lp);
    chk("C rise after LOW entry", n, 32'd3);
    drain(40, "C drain2");

    // Ch3 ratio 10 with an invalid select; ch0 keeps running at ratio 4.
    reset_pulse();
    set_ch(3, 3'b001, 1'b1, 1'b0);
    set_ch(0, 3'b011, 1'b1, 1'b0);
    push(3, 1'b0, 0);
    for (int k = 0; k < 3; k++) begin
      push(3, 1'b1, 5); push(3, 1'b0, 5);
    end
    push(0, 1'b0, 0);
    for (int k = 0; k < 5; k++) begin
      push(0, 1'b1, 2); push(0, 1'b0, 2);
    end
    wait_rise(3, 40, "D rise", n, lp);
    set_ch(3, 3'b111, 1'b1, 1'b0);
    @(negedge clk);
    chk("D pend3 invalid sel", sw_pending[3], 1'b0);
    chk("D pend0", sw_pending[0], 1'b0);
    drain(200, "D drain");

    // All channels running; reset pulsed mid-high with a change pending.
    reset_pulse();
    set_ch(0, 3'b011, 1'b1, 1'b0);
    set_ch(1, 3'b000, 1'b1, 1'b0);
    set_ch(2, 3'b010, 1'b1, 1'b0);
    set_ch(3, 3'b001, 1'b1, 1'b0);
    wait_rise(1, 40, "E rise", n, lp);
    set_ch(1, 3'b100, 1'b1, 1'b0);
    @(negedge clk);
    chk("E pend1 before reset", sw_pending[1], 1'b1);
    chk("E unit_clk1 before reset", unit_clk[1], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("E async unit_clk", unit_clk, 4'h0);
    chk("E async clk_active", clk_active, 4'h0);
    chk("E async sw_pending", sw_pending, 4'h0);
    for (int c = 0; c < NCH; c++) set_ch(c, 3'b101, 1'b1, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      push(c, 1'b0, 0);
      push(c, 1'b1, 6); push(c, 1'b0, 6); push(c, 1'b1, 6);
    end
    @(negedge clk);
    chk("E act after release", clk_active, 4'hF);
    chk("E pend after release", sw_pending, 4'h0);
    drain(100, "E drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
